seq_muldiv_alu: RTL

SEQ_MULDIV_ALU -- requirements
Module: seq_muldiv_alu

---
 rtl/alu_pkg.sv | 33 +++
 rtl/muldiv_iter.sv | 85 ++++++++
 rtl/seq_muldiv_alu.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and counter sizing for seq_muldiv_alu.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SLL    = 5'b00001;
  localparam logic [4:0] OP_SLT    = 5'b00010;
  localparam logic [4:0] OP_SLTU   = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_OR     = 5'b00110;
  localparam logic [4:0] OP_AND    = 5'b00111;
  localparam logic [4:0] OP_SUB    = 5'b01000;
  localparam logic [4:0] OP_SRA    = 5'b01101;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider: one bit per cycle, XLEN cycles.
module muldiv_iter import alu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CNT_W = cnt_width(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic              busy, neg_q, dz_q;
  logic [2:0]        fn_q;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   a_q, mcand;
  // mul: {accumulator, multiplier}; div: {remainder, quotient}
  logic [2*XLEN-1:0] prod, step, mul_s;
  logic [XLEN:0]     acc, rem_sh, rem_sub;
  logic [XLEN-1:0]   quo_s, rem_s, fin, a_mag, b_mag;
  logic              ge, a_sgn, b_sgn, a_neg, b_neg, neg_s;

  assign done = busy && (cnt == CNT_W'(XLEN - 1));

  // Operands are reduced to magnitudes; the sign is reapplied at the end.
  always_comb begin
    a_sgn = fn[2] ? !fn[0] : (fn[1:0] == 2'b01 || fn[1:0] == 2'b10);
    b_sgn = fn[2] ? !fn[0] : (fn[1:0] == 2'b01);
    a_neg = a_sgn && a[XLEN-1];
    b_neg = b_sgn && b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    neg_s = (fn[2] && fn[1]) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    acc     = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    rem_sh  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    rem_sub = rem_sh - {1'b0, mcand};
    ge      = rem_sh >= {1'b0, mcand};
    if (fn_q[2]) step = {(ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0]), prod[XLEN-2:0], ge};
    else         step = {acc, prod[XLEN-1:1]};
  end

  always_comb begin
    mul_s = neg_q ? -step : step;
    quo_s = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem_s = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    fin   = '0;
    if (!fn_q[2]) fin = (fn_q[1:0] == 2'b00) ? mul_s[XLEN-1:0] : mul_s[2*XLEN-1:XLEN];
    else if (fn_q[1]) fin = dz_q ? a_q : rem_s;
    else fin = dz_q ? '1 : quo_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; cnt <= '0; fn_q <= '0; neg_q <= 1'b0; dz_q <= 1'b0;
      a_q <= '0; mcand <= '0; prod <= '0; result <= '0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      fn_q  <= fn;
      neg_q <= neg_s;
      dz_q  <= (b == '0);
      a_q   <= a;
      mcand <= b_mag;
      prod  <= {{XLEN{1'b0}}, a_mag};
    end else if (busy) begin
      prod <= step;
      cnt  <= cnt + 1'b1;
      if (done) begin
        busy   <= 1'b0;
        result <= fin;
      end
    end
  end

endmodule

// File: rtl/seq_muldiv_alu.sv
// Sequential ALU: single-cycle base ops plus iterative MUL/DIV/REM behind a valid/ready handshake.
module seq_muldiv_alu import alu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CNT_W = cnt_width(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            carry,
  output logic            negative,
  output logic            overflow
);

  localparam int SH_W = $clog2(XLEN);

  state_t          state, state_nxt;
  logic            accept, md_done, md_sel;
  logic [XLEN-1:0] md_res, alu_res, res_q, diff;
  logic [XLEN:0]   sum;
  logic [SH_W-1:0] shamt;
  logic            alu_c, alu_v, zero_q, neg_q, carry_q, ovf_q;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready && !flush;

  muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_md (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(accept && op[4]),
    .fn(op[2:0]), .a(a), .b(b), .done(md_done), .result(md_res)
  );

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = a - b;
  assign shamt = b[SH_W-1:0];

  // Iterative ops match no case item, so their carry/overflow latch as 0.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[XLEN-1:0];
        alu_c   = sum[XLEN];
        alu_v   = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = a < b;
        alu_v   = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      end
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = XLEN'($signed(a) < $signed(b));
      OP_SLTU: alu_res = XLEN'(a < b);
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SRA:  alu_res = XLEN'($signed(a) >>> shamt);
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (in_valid) state_nxt = op[4] ? S_CALC : S_DONE;
        S_CALC:  if (md_done) state_nxt = S_DONE;
        S_DONE:  if (out_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_sel <= 1'b0; res_q <= '0; zero_q <= 1'b0; neg_q <= 1'b0; carry_q <= 1'b0; ovf_q <= 1'b0;
    end else if (accept) begin
      md_sel  <= op[4];
      res_q   <= alu_res;
      zero_q  <= (alu_res == '0);
      neg_q   <= alu_res[XLEN-1];
      carry_q <= alu_c;
      ovf_q   <= alu_v;
    end
  end

  // The iterative unit registers its own result on the final iteration edge.
  assign result   = md_sel ? md_res : res_q;
  assign zero     = md_sel ? (md_res == '0) : zero_q;
  assign negative = md_sel ? md_res[XLEN-1] : neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule
